// File: rtl/seq_compare.sv
// Iterative chunked subtractor producing difference, not-equal and signed/unsigned
// less-than through a valid/ready handshake; one CHUNK-bit slice per cycle, LSB first.
module seq_compare #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             is_not_equal,
  output logic             is_less_than
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CHUNK-1:0] LOW_MASK = {CHUNK{1'b1}} >> 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q, carry, nz;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] a_chunk, b_chunk, low_sum;
  logic [CHUNK:0]   sum;
  logic             c_msb, last, accept, lt_unsigned, lt_signed;

  always_comb begin
    a_chunk     = a_q[int'(idx) * CHUNK +: CHUNK];
    b_chunk     = b_q[int'(idx) * CHUNK +: CHUNK];
    sum         = {1'b0, a_chunk} + {1'b0, ~b_chunk} + (CHUNK + 1)'(carry);
    // Carry into the chunk MSB: same add with the top bit masked off.
    low_sum     = (a_chunk & LOW_MASK) + (~b_chunk & LOW_MASK) + CHUNK'(carry);
    c_msb       = low_sum[CHUNK-1];
    last        = (idx == IDX_LAST);
    lt_unsigned = ~sum[CHUNK];
    lt_signed   = sum[CHUNK-1] ^ (c_msb ^ sum[CHUNK]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN:  if (last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      signed_q     <= 1'b0;
      carry        <= 1'b1;
      nz           <= 1'b0;
      idx          <= '0;
      diff         <= '0;
      is_not_equal <= 1'b0;
      is_less_than <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (accept) begin
        a_q      <= data_a;
        b_q      <= data_b;
        signed_q <= is_signed;
        carry    <= 1'b1;
        nz       <= 1'b0;
        idx      <= '0;
      end else if (state == RUN) begin
        diff[int'(idx) * CHUNK +: CHUNK] <= sum[CHUNK-1:0];
        carry <= sum[CHUNK];
        nz    <= nz | (|sum[CHUNK-1:0]);
        if (last) begin
          is_not_equal <= nz | (|sum[CHUNK-1:0]);
          is_less_than <= signed_q ? lt_signed : lt_unsigned;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule
